// File: rtl/spi_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spi_fifo_ctrl
//  Purpose  : Byte-level command engine behind an SPI slave. Each SSEL
//             session carries one command byte (WRITE / READ / STATUS /
//             CLEAR) followed by a data phase. Owns a circular byte FIFO
//             of 2^DEPTH_LOG2 entries.
//  Ports    : clk, reset_n        - clock, async active-low reset
//             rx_data, rx_valid   - received byte and its one-cycle strobe
//             tx_request          - slave asks for the next transmit byte
//             session_end         - high while SSEL is inactive
//             tx_data, tx_ready   - response byte and its one-cycle strobe
//             fifo_count          - FIFO occupancy, 0..2^DEPTH_LOG2
//             overflow, underflow - sticky error flags (cleared by CLEAR)
//  Revision : 1.0 - initial release
// ============================================================================
module spi_fifo_ctrl #(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    input  logic                  tx_request,
    input  logic                  session_end,
    output logic [7:0]            tx_data,
    output logic                  tx_ready,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int                  c_depth      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_full_count = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_write  = 3'd1;
    localparam logic [2:0] c_st_read   = 3'd2;
    localparam logic [2:0] c_st_status = 3'd3;
    localparam logic [2:0] c_st_ignore = 3'd4;

    localparam logic [7:0] c_cmd_write  = 8'h01;
    localparam logic [7:0] c_cmd_read   = 8'h02;
    localparam logic [7:0] c_cmd_status = 8'h03;
    localparam logic [7:0] c_cmd_clear  = 8'h04;

    localparam logic [7:0] c_resp_sync   = 8'hA5;
    localparam logic [7:0] c_resp_zero   = 8'h00;
    localparam logic [7:0] c_resp_ignore = 8'hFF;

    logic [2:0]            r_state;
    logic [2:0]            w_state_next;
    logic [7:0]            r_mem [0:c_depth-1];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic                  r_status_first;
    logic [7:0]            r_tx_data;
    logic                  r_tx_ready;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_flush;
    logic                  w_set_ovf;
    logic                  w_set_udf;
    logic                  w_status_first_next;
    logic [7:0]            w_resp;

    assign w_full  = (r_count == c_full_count);
    assign w_empty = (r_count == '0);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next state, FIFO strobes and response selection. The received byte is
    // applied first so that a command arriving together with tx_request is
    // already in effect for the response (e.g. READ pops immediately).
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next        = r_state;
        w_push              = 1'b0;
        w_pop               = 1'b0;
        w_flush             = 1'b0;
        w_set_ovf           = 1'b0;
        w_set_udf           = 1'b0;
        w_status_first_next = r_status_first;
        w_resp              = c_resp_zero;

        if (session_end) begin
            w_state_next = c_st_idle;
        end else if (rx_valid) begin
            case (r_state)
                c_st_idle: begin
                    case (rx_data)
                        c_cmd_write:  w_state_next = c_st_write;
                        c_cmd_read:   w_state_next = c_st_read;
                        c_cmd_status: begin
                            w_state_next        = c_st_status;
                            w_status_first_next = 1'b1;
                        end
                        c_cmd_clear: begin
                            w_state_next = c_st_ignore;
                            w_flush      = 1'b1;
                        end
                        default:      w_state_next = c_st_ignore;
                    endcase
                end
                c_st_write: begin
                    if (w_full) begin
                        w_set_ovf = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (tx_request) begin
            if (session_end) begin
                w_resp = c_resp_sync;
            end else begin
                case (w_state_next)
                    c_st_idle:  w_resp = c_resp_sync;
                    c_st_write: w_resp = c_resp_zero;
                    c_st_read: begin
                        if (w_empty) begin
                            w_set_udf = 1'b1;
                        end else begin
                            w_pop  = 1'b1;
                            w_resp = r_mem[r_rd_ptr];
                        end
                    end
                    c_st_status: begin
                        if (w_status_first_next) begin
                            w_resp = {w_full, w_empty, r_overflow, r_underflow, 4'b0000};
                            w_status_first_next = 1'b0;
                        end else begin
                            w_resp = 8'(r_count);
                        end
                    end
                    default:    w_resp = c_resp_ignore;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // FIFO bookkeeping and sticky flags. Push and pop are mutually exclusive
    // because they can only happen in WRITE and READ respectively.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
            r_status_first <= 1'b1;
        end else begin
            r_status_first <= w_status_first_next;
            if (w_flush) begin
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
                r_count     <= '0;
                r_overflow  <= 1'b0;
                r_underflow <= 1'b0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                    r_count  <= r_count + 1'b1;
                end else if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                    r_count  <= r_count - 1'b1;
                end
                if (w_set_ovf) begin
                    r_overflow <= 1'b1;
                end
                if (w_set_udf) begin
                    r_underflow <= 1'b1;
                end
            end
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= rx_data;
        end
    end

    // ------------------------------------------------------------------------
    // Transmit handshake: one-cycle strobe one clock after tx_request, data
    // held until the next request.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_tx_data  <= 8'h00;
            r_tx_ready <= 1'b0;
        end else begin
            r_tx_ready <= tx_request;
            if (tx_request) begin
                r_tx_data <= w_resp;
            end
        end
    end

    assign tx_data    = r_tx_data;
    assign tx_ready   = r_tx_ready;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;
    assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_spi_fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_fifo_ctrl
//  Purpose  : Self-checking bench for spi_fifo_ctrl (DEPTH_LOG2 = 2).
//             A vector table drives one clock per entry; expected response
//             bytes go into a queue and are matched as tx_ready pulses out.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_fifo_ctrl;

    localparam int DL = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          tx_request = 1'b0;
    logic          session_end = 1'b1;
    logic [7:0]    tx_data;
    logic          tx_ready;
    logic [DL:0]   fifo_count;
    logic          overflow;
    logic          underflow;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [7:0]    sb_q[$];
    logic [7:0]    mon_exp;

    spi_fifo_ctrl #(.DEPTH_LOG2(DL)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_request  (tx_request),
        .session_end (session_end),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .fifo_count  (fifo_count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        se;
        logic        rxv;
        logic [7:0]  rx;
        logic        txr;
        logic [7:0]  exp_tx;
        logic [DL:0] exp_cnt;
        logic        exp_ovf;
        logic        exp_udf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic se, logic rxv, logic [7:0] rx, logic txr,
                                logic [7:0] exp_tx, int cnt, logic ovf, logic udf);
        vec_t v;
        v.se = se; v.rxv = rxv; v.rx = rx; v.txr = txr; v.exp_tx = exp_tx;
        v.exp_cnt = cnt[DL:0]; v.exp_ovf = ovf; v.exp_udf = udf;
        return v;
    endfunction

    function automatic void add(logic se, logic rxv, logic [7:0] rx, logic txr,
                                logic [7:0] exp_tx, int cnt, logic ovf, logic udf);
        vecs.push_back(mk(se, rxv, rx, txr, exp_tx, cnt, ovf, udf));
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive one vector for exactly one clock (entered and left at negedge).
    task automatic apply(vec_t v, int idx);
        session_end = v.se;
        rx_valid    = v.rxv;
        rx_data     = v.rx;
        tx_request  = v.txr;
        if (v.txr) sb_q.push_back(v.exp_tx);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d tx_ready", idx), 32'(tx_ready), 32'(v.txr));
        chk($sformatf("v%0d fifo_count", idx), 32'(fifo_count), 32'(v.exp_cnt));
        chk($sformatf("v%0d overflow", idx), 32'(overflow), 32'(v.exp_ovf));
        chk($sformatf("v%0d underflow", idx), 32'(underflow), 32'(v.exp_udf));
    endtask

    // Scoreboard: every tx_ready pulse consumes the oldest expected byte.
    always @(negedge clk) begin
        if (reset_n && tx_ready) begin
            n_tests++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL tx_data unexpected: got %0h, expected no response", tx_data);
            end else begin
                mon_exp = sb_q.pop_front();
                if (tx_data !== mon_exp) begin
                    n_fail++;
                    $display("FAIL tx_data: got %0h, expected %0h", tx_data, mon_exp);
                end
            end
        end
    end

    initial begin
        // write 0x11,0x22,0x33
        add(1,0,8'h00,0,8'h00,0,0,0);
        add(0,0,8'h00,1,8'hA5,0,0,0);
        add(0,1,8'h01,1,8'h00,0,0,0);
        add(0,1,8'h11,1,8'h00,1,0,0);
        add(0,1,8'h22,1,8'h00,2,0,0);
        add(0,1,8'h33,0,8'h00,3,0,0);
        add(1,0,8'h00,0,8'h00,3,0,0);
        // read them back
        add(0,0,8'h00,1,8'hA5,3,0,0);
        add(0,1,8'h02,1,8'h11,2,0,0);
        add(0,1,8'h00,1,8'h22,1,0,0);
        add(0,1,8'h00,1,8'h33,0,0,0);
        add(0,1,8'h00,0,8'h00,0,0,0);
        add(1,0,8'h00,0,8'h00,0,0,0);
        // overflow: 5 pushes into depth 4
        add(0,1,8'h01,0,8'h00,0,0,0);
        add(0,1,8'h01,0,8'h00,1,0,0);
        add(0,1,8'h02,0,8'h00,2,0,0);
        add(0,1,8'h03,0,8'h00,3,0,0);
        add(0,1,8'h04,0,8'h00,4,0,0);
        add(0,1,8'h05,0,8'h00,4,1,0);
        add(1,0,8'h00,0,8'h00,4,1,0);
        add(0,1,8'h02,1,8'h01,3,1,0);
        add(0,1,8'h00,1,8'h02,2,1,0);
        add(0,0,8'h00,1,8'h03,1,1,0);
        add(0,0,8'h00,1,8'h04,0,1,0);
        add(1,0,8'h00,0,8'h00,0,1,0);
        // status with 2 queued and overflow set, then clear
        add(0,1,8'h01,0,8'h00,0,1,0);
        add(0,1,8'hAA,0,8'h00,1,1,0);
        add(0,1,8'hBB,0,8'h00,2,1,0);
        add(1,0,8'h00,0,8'h00,2,1,0);
        add(0,1,8'h03,1,8'h20,2,1,0);
        add(0,1,8'h00,1,8'h02,2,1,0);
        add(0,1,8'h00,1,8'h02,2,1,0);
        add(1,0,8'h00,0,8'h00,2,1,0);
        add(0,1,8'h04,1,8'hFF,0,0,0);
        add(1,0,8'h00,0,8'h00,0,0,0);
        // underflow on empty read, then status shows empty+underflow
        add(0,1,8'h02,1,8'h00,0,0,1);
        add(0,1,8'h00,1,8'h00,0,0,1);
        add(1,0,8'h00,0,8'h00,0,0,1);
        add(0,1,8'h03,1,8'h50,0,0,1);
        add(1,0,8'h00,0,8'h00,0,0,1);
        // session end mid-write; next byte is a command
        add(0,1,8'h04,0,8'h00,0,0,0);
        add(1,0,8'h00,0,8'h00,0,0,0);
        add(0,1,8'h01,0,8'h00,0,0,0);
        add(0,1,8'h10,0,8'h00,1,0,0);
        add(0,1,8'h20,0,8'h00,2,0,0);
        add(1,1,8'h30,1,8'hA5,2,0,0);
        add(0,1,8'h02,1,8'h10,1,0,0);
        add(1,0,8'h00,0,8'h00,1,0,0);
        // fill to full, status shows full, later count
        add(0,1,8'h01,0,8'h00,1,0,0);
        add(0,1,8'h21,0,8'h00,2,0,0);
        add(0,1,8'h22,0,8'h00,3,0,0);
        add(0,1,8'h23,0,8'h00,4,0,0);
        add(1,0,8'h00,0,8'h00,4,0,0);
        add(0,1,8'h03,1,8'h80,4,0,0);
        add(0,1,8'h00,1,8'h04,4,0,0);
        add(1,0,8'h00,0,8'h00,4,0,0);
        // back-to-back requests
        add(0,1,8'h02,1,8'h20,3,0,0);
        add(0,0,8'h00,1,8'h21,2,0,0);
        add(0,0,8'h00,1,8'h22,1,0,0);
        add(1,0,8'h00,0,8'h00,1,0,0);
        // unknown command -> IGNORE, later bytes not decoded
        add(0,1,8'h07,1,8'hFF,1,0,0);
        add(0,1,8'h02,1,8'hFF,1,0,0);
        add(1,0,8'h00,0,8'h00,1,0,0);

        // reset state
        #1;
        chk("reset tx_data", 32'(tx_data), 32'h00);
        chk("reset tx_ready", 32'(tx_ready), 32'h0);
        chk("reset fifo_count", 32'(fifo_count), 32'h0);
        chk("reset overflow", 32'(overflow), 32'h0);
        chk("reset underflow", 32'(underflow), 32'h0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // async reset mid-READ with 3 entries (0x23,0x41,0x42)
        apply(mk(0,1,8'h01,0,8'h00,1,0,0), 100);
        apply(mk(0,1,8'h41,0,8'h00,2,0,0), 101);
        apply(mk(0,1,8'h42,0,8'h00,3,0,0), 102);
        apply(mk(1,0,8'h00,0,8'h00,3,0,0), 103);
        apply(mk(0,1,8'h02,0,8'h00,3,0,0), 104);
        apply(mk(0,0,8'h00,1,8'h23,2,0,0), 105);
        rx_valid   = 1'b0;
        tx_request = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("midreset tx_data", 32'(tx_data), 32'h00);
        chk("midreset tx_ready", 32'(tx_ready), 32'h0);
        chk("midreset fifo_count", 32'(fifo_count), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        apply(mk(0,0,8'h00,1,8'hA5,0,0,0), 106);

        session_end = 1'b1;
        rx_valid    = 1'b0;
        tx_request  = 1'b0;
        repeat (3) @(negedge clk);
        chk("scoreboard drained", 32'(sb_q.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
